collision_scan_ctrl: RTL and testbench
======================================

# collision_scan_ctrl

Sequencer that runs the per-tick snake collision check as a multi-cycle scan instead of a single-cycle comparison across every body segment. Each game tick it latches the head position, runs the boundary check, then walks the body store one segment per cycle through a synchronous read port. It then resolves the outcome into lives, length and respawn position. It sits between the game-step timer, the snake body memory and the random number generator, and it drives the game-over state.

## Interface
- COORD_WIDTH, 10, coordinate width
- LENGTH_WIDTH, 6, snake length and body-address width
- DISPLAY_WIDTH, 64, playfield width in blocks
- DISPLAY_HEIGHT, 48, playfield height in blocks
- INIT_LIVES, 3, lives after reset (3-bit)

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- tick  in  1  game-step pulse; requests one check
- head_x, head_y  in  COORD_WIDTH  head position, sampled on accepted tick
- snake_length  in  LENGTH_WIDTH  segment count, sampled on accepted tick
- body_rd_addr  out  LENGTH_WIDTH  body memory read address
- body_rd_x, body_rd_y  in  COORD_WIDTH  read data, valid 1 cycle after address
- rand  in  16  random word, sampled in RESOLVE
- busy  out  1  high in BOUND/SCAN/RESOLVE
- done  out  1  one-cycle pulse, result valid
- collision  out  1  result of last check, held until next done
- lives  out  3  remaining lives
- length_out  out  LENGTH_WIDTH  length after check
- respawn_valid  out  1  pulses with done when collision
- respawn_x, respawn_y  out  COORD_WIDTH  new head position
- game_over  out  1  sticky until reset
- tick_overrun  out  1  pulse: tick arrived while busy

## Operation
- States: IDLE, BOUND, SCAN, RESOLVE, OVER.
- IDLE: on tick, latch head_x, head_y and snake_length, then go to BOUND.
- BOUND: hit if x==0, y==0, x>=DISPLAY_WIDTH or y>=DISPLAY_HEIGHT.
  - Hit, or latched length<=1: go to RESOLVE.
  - Otherwise: go to SCAN.
- SCAN:
  - Issue addresses 1..L-1, one per cycle.
  - Compare each returned pair against the latched head.
  - First match: stop issuing and go to RESOLVE (early exit).
  - Address 0, which holds the head, is never compared.
- RESOLVE with collision:
  - lives = lives-1
  - length_out = 1
  - respawn_x = rand[7:0] % (DISPLAY_WIDTH-4) + 2
  - respawn_y = rand[15:8] % (DISPLAY_HEIGHT-4) + 2
  - respawn_valid = 1
- RESOLVE without collision: length_out = latched length; lives unchanged.
- Lives reaching 0 in RESOLVE: game_over=1, next state OVER. Otherwise next state IDLE.
- OVER: ticks ignored (no overrun pulse); exits only on reset.
- Arithmetic: lives never decremented below 0. Modulo uses unsigned 8-bit operands; results zero-extended to COORD_WIDTH.
- Ticks while busy are dropped and tick_overrun pulses; the in-flight check is unaffected.

## Timing
- Tick sampled at cycle 0; BOUND occupies cycle 1.
- Boundary hit or L<=1: RESOLVE in cycle 2; done/outputs visible in cycle 3.
- Scan, no hit: address i driven in cycle 1+i, compared in cycle 2+i; done in cycle L+3.
- Scan, first hit at segment k: done in cycle k+4.
- done, respawn_valid and tick_overrun are single-cycle registered pulses; all other outputs are registered and hold their values.
- Next tick accepted in the cycle done is high (state is IDLE).
- Reset values: lives=INIT_LIVES, length_out=1, body_rd_addr=0, respawn_x=respawn_y=0; done, collision, respawn_valid, busy, game_over and tick_overrun all 0; state IDLE.
- Reset mid-scan abandons the check with no done pulse.
- Reset and tick in the same cycle: reset wins and the tick is dropped.

## Configuration
- SNAKE_SELF_COLLISION_EN defined: behaviour as above, including SCAN.
- Undefined: SCAN state and body_rd compare logic removed; BOUND always proceeds to RESOLVE (done in cycle 3); body_rd_addr tied to 0.

## Structure
- Shared package snake_pkg holds:
  - COORD_WIDTH, LENGTH_WIDTH, DISPLAY_WIDTH, DISPLAY_HEIGHT
  - state enum
  - respawn margin constant (2)
- One sub-module, spawn_mapper: combinational rand-to-coordinate mapping, reused by the food placer.

## Test plan
- Head (0,5), L=4, lives=3, tick → done cycle 3, collision=1, lives=2, length_out=1; rand=0x1234 gives respawn (0x34%60+2=54, 0x12%44+2=20).
- Head (10,10), L=5, segment 3 = (10,10) → done cycle 7, collision=1, body_rd_addr stops at 3.
- Head (10,10), L=5, no match → done cycle 8, collision=0, length_out=5, lives unchanged.
- Three successive boundary hits from reset → lives 2,1,0; game_over=1 after the third; further ticks give no done.
- Tick in cycle 2 of a 20-segment scan → tick_overrun pulse; original result unchanged.
- Reset asserted mid-SCAN → no done; lives=3, busy=0 on the next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared playfield geometry, respawn margin and scan FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int COORD_WIDTH    = 10;
  localparam int LENGTH_WIDTH   = 6;
  localparam int DISPLAY_WIDTH  = 64;
  localparam int DISPLAY_HEIGHT = 48;
  localparam int RESPAWN_MARGIN = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BOUND   = 3'd1,
    ST_SCAN    = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/collision_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : collision_scan_ctrl_if
// Brief    : Tick request, body-memory read port and check results.
// Revision : 1.0 - initial release
// ============================================================================
interface collision_scan_ctrl_if;
  import snake_pkg::*;

  logic                    tick;
  logic [COORD_WIDTH-1:0]  head_x;
  logic [COORD_WIDTH-1:0]  head_y;
  logic [LENGTH_WIDTH-1:0] snake_length;
  logic [LENGTH_WIDTH-1:0] body_rd_addr;
  logic [COORD_WIDTH-1:0]  body_rd_x;
  logic [COORD_WIDTH-1:0]  body_rd_y;
  logic [15:0]             rand_word;
  logic                    busy;
  logic                    done;
  logic                    collision;
  logic [2:0]              lives;
  logic [LENGTH_WIDTH-1:0] length_out;
  logic                    respawn_valid;
  logic [COORD_WIDTH-1:0]  respawn_x;
  logic [COORD_WIDTH-1:0]  respawn_y;
  logic                    game_over;
  logic                    tick_overrun;

  modport master (
    output tick, head_x, head_y, snake_length, body_rd_x, body_rd_y, rand_word,
    input  body_rd_addr, busy, done, collision, lives, length_out,
    input  respawn_valid, respawn_x, respawn_y, game_over, tick_overrun
  );

  modport slave (
    input  tick, head_x, head_y, snake_length, body_rd_x, body_rd_y, rand_word,
    output body_rd_addr, busy, done, collision, lives, length_out,
    output respawn_valid, respawn_x, respawn_y, game_over, tick_overrun
  );

endinterface
`default_nettype wire

// File: rtl/spawn_mapper.sv
`default_nettype none
// ============================================================================
// Module   : spawn_mapper
// Brief    : Maps a random word to a playfield coordinate inside the margin.
// Revision : 1.0 - initial release
// ============================================================================
module spawn_mapper
  import snake_pkg::*;
(
  input  logic [15:0]            i_rand,
  output logic [COORD_WIDTH-1:0] o_x,
  output logic [COORD_WIDTH-1:0] o_y
);

  localparam logic [7:0] c_x_span = 8'(DISPLAY_WIDTH - 2 * RESPAWN_MARGIN);
  localparam logic [7:0] c_y_span = 8'(DISPLAY_HEIGHT - 2 * RESPAWN_MARGIN);

  logic [7:0] w_mod_x;
  logic [7:0] w_mod_y;

  assign w_mod_x = i_rand[7:0] % c_x_span;
  assign w_mod_y = i_rand[15:8] % c_y_span;
  assign o_x     = COORD_WIDTH'(w_mod_x) + COORD_WIDTH'(RESPAWN_MARGIN);
  assign o_y     = COORD_WIDTH'(w_mod_y) + COORD_WIDTH'(RESPAWN_MARGIN);

endmodule
`default_nettype wire

// File: rtl/collision_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : collision_scan_ctrl
// Brief    : Multi-cycle per-tick collision scan; SNAKE_SELF_COLLISION_EN
//            enables the body-segment walk, otherwise boundary check only.
// Revision : 1.0 - initial release
// ============================================================================
module collision_scan_ctrl
  import snake_pkg::*;
#(
  parameter logic [2:0] INIT_LIVES = 3'd3
) (
  input  logic                  clk,
  input  logic                  reset,
  collision_scan_ctrl_if.slave  bus
);

  state_t                  r_state, w_state_nxt;
  logic [COORD_WIDTH-1:0]  r_head_x, w_head_x_nxt, r_head_y, w_head_y_nxt;
  logic [LENGTH_WIDTH-1:0] r_len, w_len_nxt;
  logic                    r_hit, w_hit_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_collision, w_collision_nxt;
  logic [2:0]              r_lives, w_lives_nxt;
  logic [LENGTH_WIDTH-1:0] r_length_out, w_length_out_nxt;
  logic                    r_resp_vld, w_resp_vld_nxt;
  logic [COORD_WIDTH-1:0]  r_resp_x, w_resp_x_nxt, r_resp_y, w_resp_y_nxt;
  logic                    r_game_over, w_game_over_nxt;
  logic                    r_overrun, w_overrun_nxt;
  logic                    w_bound_hit;
  logic [COORD_WIDTH-1:0]  w_spawn_x, w_spawn_y;

`ifdef SNAKE_SELF_COLLISION_EN
  // r_cmp_idx names the segment whose data is on body_rd_x/y this cycle
  logic [LENGTH_WIDTH-1:0] r_addr, w_addr_nxt, r_cmp_idx, w_cmp_idx_nxt;
  logic                    r_cmp_vld, w_cmp_vld_nxt;
  logic                    w_seg_match;
  assign w_seg_match      = (bus.body_rd_x == r_head_x) && (bus.body_rd_y == r_head_y);
  assign bus.body_rd_addr = r_addr;
`else
  logic w_unused_body;
  assign w_unused_body    = ^{bus.body_rd_x, bus.body_rd_y};
  assign bus.body_rd_addr = '0;
`endif

  assign w_bound_hit = (r_head_x == '0) || (r_head_y == '0) ||
                       (r_head_x >= COORD_WIDTH'(DISPLAY_WIDTH)) ||
                       (r_head_y >= COORD_WIDTH'(DISPLAY_HEIGHT));

  spawn_mapper u_spawn (
    .i_rand (bus.rand_word),
    .o_x    (w_spawn_x),
    .o_y    (w_spawn_y)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_head_x_nxt     = r_head_x;
    w_head_y_nxt     = r_head_y;
    w_len_nxt        = r_len;
    w_hit_nxt        = r_hit;
    w_done_nxt       = 1'b0;
    w_collision_nxt  = r_collision;
    w_lives_nxt      = r_lives;
    w_length_out_nxt = r_length_out;
    w_resp_vld_nxt   = 1'b0;
    w_resp_x_nxt     = r_resp_x;
    w_resp_y_nxt     = r_resp_y;
    w_game_over_nxt  = r_game_over;
    w_overrun_nxt    = bus.tick && r_busy;
`ifdef SNAKE_SELF_COLLISION_EN
    w_addr_nxt       = r_addr;
    w_cmp_vld_nxt    = 1'b0;
    w_cmp_idx_nxt    = r_addr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.tick) begin
          w_head_x_nxt = bus.head_x;
          w_head_y_nxt = bus.head_y;
          w_len_nxt    = bus.snake_length;
          w_state_nxt  = ST_BOUND;
        end
      end
      ST_BOUND: begin
        w_hit_nxt = w_bound_hit;
`ifdef SNAKE_SELF_COLLISION_EN
        if (w_bound_hit || (r_len <= LENGTH_WIDTH'(1))) begin
          w_state_nxt = ST_RESOLVE;
        end else begin
          w_state_nxt = ST_SCAN;
          w_addr_nxt  = LENGTH_WIDTH'(1);
        end
`else
        w_state_nxt = ST_RESOLVE;
`endif
      end
`ifdef SNAKE_SELF_COLLISION_EN
      ST_SCAN: begin
        if (r_cmp_vld && w_seg_match) begin
          w_hit_nxt   = 1'b1;
          w_addr_nxt  = r_cmp_idx;
          w_state_nxt = ST_RESOLVE;
        end else if (r_cmp_vld && (r_cmp_idx == r_len - LENGTH_WIDTH'(1))) begin
          w_state_nxt = ST_RESOLVE;
        end else begin
          w_cmp_vld_nxt = 1'b1;
          w_cmp_idx_nxt = r_addr;
          if (r_addr != r_len - LENGTH_WIDTH'(1)) begin
            w_addr_nxt = r_addr + LENGTH_WIDTH'(1);
          end
        end
      end
`endif
      ST_RESOLVE: begin
        w_done_nxt      = 1'b1;
        w_collision_nxt = r_hit;
        w_state_nxt     = ST_IDLE;
        if (r_hit) begin
          w_lives_nxt      = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
          w_length_out_nxt = LENGTH_WIDTH'(1);
          w_resp_vld_nxt   = 1'b1;
          w_resp_x_nxt     = w_spawn_x;
          w_resp_y_nxt     = w_spawn_y;
          if (r_lives <= 3'd1) begin
            w_game_over_nxt = 1'b1;
            w_state_nxt     = ST_OVER;
          end
        end else begin
          w_length_out_nxt = r_len;
        end
      end
      ST_OVER: begin
        w_state_nxt = ST_OVER;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_head_x     <= '0;
      r_head_y     <= '0;
      r_len        <= '0;
      r_hit        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_collision  <= 1'b0;
      r_lives      <= INIT_LIVES;
      r_length_out <= LENGTH_WIDTH'(1);
      r_resp_vld   <= 1'b0;
      r_resp_x     <= '0;
      r_resp_y     <= '0;
      r_game_over  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SNAKE_SELF_COLLISION_EN
      r_addr       <= '0;
      r_cmp_idx    <= '0;
      r_cmp_vld    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_head_x     <= w_head_x_nxt;
      r_head_y     <= w_head_y_nxt;
      r_len        <= w_len_nxt;
      r_hit        <= w_hit_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_collision  <= w_collision_nxt;
      r_lives      <= w_lives_nxt;
      r_length_out <= w_length_out_nxt;
      r_resp_vld   <= w_resp_vld_nxt;
      r_resp_x     <= w_resp_x_nxt;
      r_resp_y     <= w_resp_y_nxt;
      r_game_over  <= w_game_over_nxt;
      r_overrun    <= w_overrun_nxt;
`ifdef SNAKE_SELF_COLLISION_EN
      r_addr       <= w_addr_nxt;
      r_cmp_idx    <= w_cmp_idx_nxt;
      r_cmp_vld    <= w_cmp_vld_nxt;
`endif
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.collision     = r_collision;
  assign bus.lives         = r_lives;
  assign bus.length_out    = r_length_out;
  assign bus.respawn_valid = r_resp_vld;
  assign bus.respawn_x     = r_resp_x;
  assign bus.respawn_y     = r_resp_y;
  assign bus.game_over     = r_game_over;
  assign bus.tick_overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_collision_scan_ctrl
// Brief    : Vector table plus scoreboard of expected done results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collision_scan_ctrl;

`ifdef SNAKE_SELF_COLLISION_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  typedef struct {
    int hx; int hy; int len; int k; logic [15:0] rnd;
    int lat; int coll; int lives; int leno; int rx; int ry; int go; int addr;
  } vec_t;

  typedef struct {
    int cyc; int coll; int lives; int leno; int rx; int ry; int go; int addr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ncyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tv[7];
  logic [9:0] mem_x[64];
  logic [9:0] mem_y[64];

  collision_scan_ctrl_if bus();

  collision_scan_ctrl #(.INIT_LIVES(3'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  always @(posedge clk) begin
    bus.body_rd_x <= mem_x[bus.body_rd_addr];
    bus.body_rd_y <= mem_y[bus.body_rd_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", ncyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", ncyc, e.cyc);
        chk("collision", int'(bus.collision), e.coll);
        chk("respawn_valid", int'(bus.respawn_valid), e.coll);
        chk("lives", int'(bus.lives), e.lives);
        chk("length_out", int'(bus.length_out), e.leno);
        chk("game_over", int'(bus.game_over), e.go);
        if (e.coll != 0) begin
          chk("respawn_x", int'(bus.respawn_x), e.rx);
          chk("respawn_y", int'(bus.respawn_y), e.ry);
        end
        if (e.addr >= 0) chk("body_rd_addr", int'(bus.body_rd_addr), e.addr);
      end
    end
  end

  task automatic load_mem(input int hx, input int hy, input int len, input int k);
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = 10'(100 + i);
      mem_y[i] = 10'd300;
    end
    mem_x[0] = 10'(hx);  mem_y[0] = 10'(hy);
    mem_x[1] = 10'(hx);  mem_y[1] = 10'(hy + 1);
    if (len < 64) begin
      mem_x[len] = 10'(hx);
      mem_y[len] = 10'(hy);
    end
    if (k != 0) begin
      mem_x[k] = 10'(hx);
      mem_y[k] = 10'(hy);
    end
  endtask

  task automatic push_exp(input int lat, input int coll, input int lives, input int leno,
                          input int rx, input int ry, input int go, input int addr);
    exp_t e;
    e.cyc = ncyc + lat; e.coll = coll; e.lives = lives; e.leno = leno;
    e.rx = rx; e.ry = ry; e.go = go; e.addr = addr;
    sb.push_back(e);
  endtask

  // Called at negedge+1; tick is held for exactly one cycle.
  task automatic drive_tick(input int hx, input int hy, input int len, input logic [15:0] rnd);
    bus.head_x       = 10'(hx);
    bus.head_y       = 10'(hy);
    bus.snake_length = 6'(len);
    bus.rand_word    = rnd;
    bus.tick         = 1'b1;
    @(negedge clk); #1;
    bus.tick = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_rst();
    chk("rst_lives", int'(bus.lives), 3);
    chk("rst_length_out", int'(bus.length_out), 1);
    chk("rst_body_rd_addr", int'(bus.body_rd_addr), 0);
    chk("rst_respawn_x", int'(bus.respawn_x), 0);
    chk("rst_respawn_y", int'(bus.respawn_y), 0);
    chk("rst_flags", int'({bus.done, bus.collision, bus.respawn_valid,
                           bus.busy, bus.game_over, bus.tick_overrun}), 0);
  endtask

  initial begin
    int ovr;
    bus.tick = 1'b0; bus.head_x = '0; bus.head_y = '0;
    bus.snake_length = '0; bus.rand_word = '0;
    load_mem(0, 0, 1, 0);

    //        hx  hy  len k  rnd      lat       coll lives     leno      rx  ry  go addr
    tv[0] = '{0,  5,  4,  0, 16'h1234, 3,       1,   2,        1,        54, 20, 0, S ? -1 : 0};
    tv[1] = '{10, 10, 5,  3, 16'hABCD, S ? 7:3, S,   S ? 1:2,  S ? 1:5,  27, 41, 0, S ? 3 : 0};
    tv[2] = '{10, 10, 5,  0, 16'h0000, S ? 8:3, 0,   S ? 1:2,  5,        0,  0,  0, S ? 4 : 0};
    tv[3] = '{63, 47, 1,  0, 16'h0000, 3,       0,   S ? 1:2,  1,        0,  0,  0, S ? -1 : 0};
    tv[4] = '{5,  5,  2,  0, 16'h0000, S ? 5:3, 0,   S ? 1:2,  2,        0,  0,  0, S ? 1 : 0};
    tv[5] = '{1,  1,  63, 0, 16'h0000, S ? 66:3,0,   S ? 1:2,  63,       0,  0,  0, S ? 62 : 0};
    tv[6] = '{63, 47, 3,  2, 16'hFFFF, S ? 6:3, S,   S ? 0:2,  S ? 1:3,  17, 37, S, S ? 2 : 0};

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    check_rst();

    for (int i = 0; i < 7; i++) begin
      load_mem(tv[i].hx, tv[i].hy, tv[i].len, tv[i].k);
      @(negedge clk); #1;
      push_exp(tv[i].lat, tv[i].coll, tv[i].lives, tv[i].leno,
               tv[i].rx, tv[i].ry, tv[i].go, tv[i].addr);
      drive_tick(tv[i].hx, tv[i].hy, tv[i].len, tv[i].rnd);
      wait_idle(100, "vector");
    end

    // Three boundary hits drain all lives; OVER then ignores ticks.
    do_reset();
    check_rst();
    load_mem(64, 10, 4, 0);
    push_exp(3, 1, 2, 1, 2, 2, 0, 0);
    drive_tick(64, 10, 4, 16'h0000);
    wait_idle(20, "bound1");
    push_exp(3, 1, 1, 1, 17, 37, 0, 0);
    drive_tick(10, 48, 4, 16'hFFFF);
    wait_idle(20, "bound2");
    push_exp(3, 1, 0, 1, 45, 17, 1, 0);
    drive_tick(0, 0, 4, 16'h3B2B);
    wait_idle(20, "bound3");
    ovr = 0;
    drive_tick(10, 10, 4, 16'h0000);
    repeat (8) begin
      @(negedge clk); #1;
      ovr += int'(bus.tick_overrun);
    end
    chk("over_no_overrun", ovr, 0);
    chk("over_game_over", int'(bus.game_over), 1);
    chk("over_busy", int'(bus.busy), 0);

    // A second tick during a long check is dropped with an overrun pulse.
    do_reset();
    load_mem(10, 10, 20, 0);
    push_exp(S ? 23 : 3, 0, 3, 20, 0, 0, 0, S ? 19 : 0);
    drive_tick(10, 10, 20, 16'h0000);
    @(negedge clk); #1;
    bus.tick = 1'b1;
    @(negedge clk); #1;
    bus.tick = 1'b0;
    chk("overrun_pulse", int'(bus.tick_overrun), 1);
    @(negedge clk); #1;
    chk("overrun_single", int'(bus.tick_overrun), 0);
    wait_idle(40, "overrun");
    repeat (5) @(negedge clk);

    // Reset in the middle of a check abandons it without a done pulse.
    #1;
    load_mem(0, 3, 4, 0);
    push_exp(3, 1, 2, 1, 2, 2, 0, 0);
    drive_tick(0, 3, 4, 16'h0000);
    wait_idle(20, "pre_abort");
    load_mem(10, 10, 20, 0);
    drive_tick(10, 10, 20, 16'h0000);
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_lives", int'(bus.lives), 3);
    chk("abort_done", int'(bus.done), 0);
    repeat (30) @(negedge clk);

    // Reset and tick together: the tick is lost.
    #1;
    reset = 1'b1;
    bus.head_x = '0; bus.head_y = '0; bus.snake_length = 6'd4;
    bus.tick = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    bus.tick = 1'b0;
    chk("rst_tick_busy", int'(bus.busy), 0);
    repeat (6) @(negedge clk);
    chk("rst_tick_lives", int'(bus.lives), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
